// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-(MAX_VAL+1) up/down counter with load, clear, cascade carry and wrap flags.
module mod_updown_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             wrap_sticky
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d, sticky_q, sticky_d;
    logic             at_max, at_zero, wrap_ev;
    logic [WIDTH-1:0] load_sat, step_val;
    always_comb begin
        at_max   = count_q == MAX_VAL;
        at_zero  = count_q == '0;
        // Explicit end-of-range compares keep non-power-of-two moduli exact.
        wrap_ev  = en & ~clr & ~load & (up_dn ? at_max : at_zero);
        load_sat = load_val > MAX_VAL ? MAX_VAL : load_val;
        step_val = up_dn ? (at_max ? '0 : count_q + 1'b1)
                         : (at_zero ? MAX_VAL : count_q - 1'b1);
        count_d  = clr ? '0 : load ? load_sat : en ? step_val : count_q;
        wrap_d   = wrap_ev;
        sticky_d = clr ? 1'b0 : sticky_q | wrap_ev;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            sticky_q <= sticky_d;
        end
    end
    assign count       = count_q;
    assign tc          = wrap_ev;
    assign wrap        = wrap_q;
    assign wrap_sticky = sticky_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboard bench for mod_updown_counter (MAX_VAL = 9) plus a two-digit cascade.
module tb_mod_updown_counter;
    typedef struct {
        logic [3:0] count;
        logic       wrap;
        logic       sticky;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b1;
    logic [3:0] load_val = '0;
    logic [3:0] count;
    logic       tc, wrap, wrap_sticky;
    logic       casc_en = 1'b0;
    logic [3:0] lo_count, hi_count;
    logic       lo_tc, lo_wrap, lo_sticky, hi_tc, hi_wrap, hi_sticky;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t m;

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) dut (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(count), .tc(tc), .wrap(wrap),
        .wrap_sticky(wrap_sticky)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_lo (
        .clk(clk), .reset(reset), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(casc_en), .up_dn(1'b1), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap),
        .wrap_sticky(lo_sticky)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_hi (
        .clk(clk), .reset(reset), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(lo_tc), .up_dn(1'b1), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap),
        .wrap_sticky(hi_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Predict the next state from the inputs currently driven, then compare after the edge.
    task automatic step();
        exp_t e;
        logic ev;
        #1;
        ev = en && !clr && !load && (up_dn ? m.count == 4'd9 : m.count == 4'd0);
        chk("tc", {31'b0, tc}, {31'b0, ev});
        e.count  = clr ? 4'd0 : load ? (load_val > 4'd9 ? 4'd9 : load_val) :
                   !en ? m.count : ev ? (up_dn ? 4'd0 : 4'd9) :
                   up_dn ? m.count + 4'd1 : m.count - 4'd1;
        e.wrap   = ev;
        e.sticky = clr ? 1'b0 : m.sticky | ev;
        sb_q.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("count", {28'b0, count}, {28'b0, e.count});
        chk("wrap", {31'b0, wrap}, {31'b0, e.wrap});
        chk("sticky", {31'b0, wrap_sticky}, {31'b0, e.sticky});
    endtask

    initial begin
        int hi_wraps;
        m = '{count: 4'd0, wrap: 1'b0, sticky: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {28'b0, count}, 32'd0);
        chk("rst_wrap", {31'b0, wrap}, 32'd0);
        chk("rst_sticky", {31'b0, wrap_sticky}, 32'd0);
        reset = 1'b1;
        en = 1'b1; up_dn = 1'b1;
        repeat (12) step();
        load = 1'b1; load_val = 4'd1; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        repeat (4) step();
        load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        step();
        load = 1'b1; load_val = 4'd9;
        step();
        load_val = 4'd14;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0; load = 1'b1; load_val = 4'd4; en = 1'b0;
        step();
        load = 1'b0;
        repeat (5) step();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dn = (i % 2 == 0);
            step();
        end
        up_dn = 1'b1;
        repeat (6) step();
        load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0; en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_count", {28'b0, count}, 32'd0);
        chk("async_wrap", {31'b0, wrap}, 32'd0);
        chk("async_sticky", {31'b0, wrap_sticky}, 32'd0);
        m = '{count: 4'd0, wrap: 1'b0, sticky: 1'b0};
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        en = 1'b1; up_dn = 1'b1;
        step();
        en = 1'b0;
        hi_wraps = 0;
        chk("casc_start", {24'b0, hi_count, lo_count}, 32'h00);
        casc_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (hi_wrap) hi_wraps++;
            chk("casc_val", 32'(hi_count) * 10 + 32'(lo_count), 32'(i % 100));
        end
        casc_en = 1'b0;
        @(posedge clk);
        #1;
        if (hi_wrap) hi_wraps++;
        chk("casc_hi_wraps", 32'(hi_wraps), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
